// File: rtl/pll_lock_reset_gen_pkg.sv
`default_nettype none
// ============================================================================
// pll_mon_pkg : shared types, counter sizing and parameter limits for the
//               PLL lock reset generator.
// Revision    : 1.0
// ============================================================================
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int MIN_SYNC_STAGES        = 2;
  localparam int MIN_LOCK_STABLE_CYCLES = 1;
  localparam int MIN_RST_HOLD_CYCLES    = 1;

  // One extra bit so the larger terminal count is always representable.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int m;
    m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return $clog2(m) + 1;
  endfunction

  function automatic bit params_legal(input int sync_stages, input int stable_cycles,
                                      input int hold_cycles, input int cnt_w);
    return (sync_stages >= MIN_SYNC_STAGES) &&
           (stable_cycles >= MIN_LOCK_STABLE_CYCLES) &&
           (hold_cycles >= MIN_RST_HOLD_CYCLES) &&
           (cnt_w >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_reset_gen_if.sv
`default_nettype none
// ============================================================================
// pll_lock_reset_gen_if : lock input and reset/status outputs of the generator.
// Revision              : 1.0
// ============================================================================
interface pll_lock_reset_gen_if #(
  parameter int CNT_W = 16
);
  logic             locked_in;
  logic             rst_out;
  logic             ready;
  logic             lock_lost_pulse;
  logic [CNT_W-1:0] loss_count;

  modport master (
    input  locked_in,
    output rst_out,
    output ready,
    output lock_lost_pulse,
    output loss_count
  );

  modport slave (
    output locked_in,
    input  rst_out,
    input  ready,
    input  lock_lost_pulse,
    input  loss_count
  );
endinterface
`default_nettype wire

// File: rtl/pll_lock_reset_gen_bit_sync.sv
`default_nettype none
// ============================================================================
// bit_sync : STAGES-deep single-bit synchronizer, synchronous reset to 0.
// Revision : 1.0
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_reset_gen.sv
`default_nettype none
// ============================================================================
// pll_lock_reset_gen : qualifies PLL lock and releases a clean downstream reset.
// Option             : define PLL_LOSS_COUNT_EN for the saturating loss counter.
// Revision           : 1.0
// ============================================================================
module pll_lock_reset_gen
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CNT_W              = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pll_lock_reset_gen_if.master  bus
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);

  if (!params_legal(SYNC_STAGES, LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, CNT_W)) begin : g_bad_params
    $error("pll_lock_reset_gen: illegal parameter set");
  end

  logic       locked_s;
  logic       lost_d;
  pll_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic       rst_out_q;
  logic       ready_q;
  logic       pulse_q;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.locked_in),
    .q_o (locked_s)
  );

  assign lost_d = (state_q == RUN) && !locked_s;

  // Outputs are loaded alongside the state transition so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= lost_d;
      case (state_q)
        WAIT_LOCK: begin
          cnt_q <= '0;
          if (locked_s) begin
            state_q <= STABLE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_q <= '0;
          if (!locked_s) begin
            state_q   <= WAIT_LOCK;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= WAIT_LOCK;
          cnt_q     <= '0;
          rst_out_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out         = rst_out_q;
  assign bus.ready           = ready_q;
  assign bus.lock_lost_pulse = pulse_q;

`ifdef PLL_LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lost_d && (loss_cnt_q != {CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign bus.loss_count = loss_cnt_q;
`else
  assign bus.loss_count = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_gen.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_reset_gen : directed and random lock sequences against a
//                         lock-streak reference model.
// Revision              : 1.0
// ============================================================================
module tb_pll_lock_reset_gen;

  localparam int SS    = 2;
  localparam int LS    = 8;
  localparam int RH    = 4;
  localparam int CNT_W = 2;
  // Consecutive synchronized-high samples the FSM must observe to reach RUN.
  localparam int RUN_STREAK = 1 + LS + RH;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PLL_LOSS_COUNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_lock_reset_gen_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_reset_gen #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LS),
    .RST_HOLD_CYCLES    (RH),
    .CNT_W              (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  bit pipe [SS];
  int streak = 0;
  bit m_run = 1'b0;
  bit m_pulse = 1'b0;
  int m_lc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit obs;
    bit was_run;
    if (r) begin
      for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
      streak  = 0;
      m_run   = 1'b0;
      m_pulse = 1'b0;
      m_lc    = 0;
    end else begin
      obs = pipe[SS-1];
      for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = l;
      was_run = m_run;
      streak  = obs ? ((streak < RUN_STREAK) ? streak + 1 : RUN_STREAK) : 0;
      m_run   = (streak >= RUN_STREAK);
      m_pulse = was_run && !obs;
      if (m_pulse && FEAT && (m_lc < CNT_MAX)) m_lc = m_lc + 1;
    end
  endtask

  task automatic tick(input bit r, input bit l);
    rst = r;
    bus.locked_in = l;
    @(posedge clk);
    model_edge(r, l);
    #1;
    chk("rst_out", {31'd0, bus.rst_out}, {31'd0, !m_run});
    chk("ready", {31'd0, bus.ready}, {31'd0, m_run});
    chk("lock_lost_pulse", {31'd0, bus.lock_lost_pulse}, {31'd0, m_pulse});
    chk("loss_count", {30'd0, bus.loss_count}, m_lc);
  endtask

  // Edge index (edge 0 = first tick) at which ready rises; 99 if never.
  task automatic lock_latency(output int lat);
    lat = 99;
    for (int e = 0; e < 40; e++) begin
      tick(1'b0, 1'b1);
      if (bus.ready === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic loss_latency(output int lat);
    lat = 99;
    for (int e = 0; e < 20; e++) begin
      tick(1'b0, 1'b0);
      if (bus.rst_out === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seg;
    int len;
    bit lvl;

    for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
    bus.locked_in = 1'b0;

    // Reset and idle with no lock
    repeat (3) tick(1'b1, 1'b0);
    repeat (50) tick(1'b0, 1'b0);
    chk("idle_rst_out", {31'd0, bus.rst_out}, 32'd1);

    // Clean lock
    lock_latency(lat);
    chk("clean_lock_edge", lat, SS + LS + RH);
    repeat (10) tick(1'b0, 1'b1);

    // Loss in RUN
    loss_latency(lat);
    chk("loss_edge", lat, SS);
    repeat (5) tick(1'b0, 1'b0);
    chk("loss_count_one", {30'd0, bus.loss_count}, FEAT ? 32'd1 : 32'd0);

    // Glitch during STABLE restarts qualification
    repeat (5) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    lock_latency(lat);
    chk("glitch_relock_edge", lat, SS + LS + RH);
    chk("glitch_no_count", {30'd0, bus.loss_count}, FEAT ? 32'd1 : 32'd0);

    // Repeated losses exercise saturation
    for (int k = 0; k < 5; k++) begin
      repeat (6) tick(1'b0, 1'b1);
      repeat (4) tick(1'b0, 1'b0);
      lock_latency(lat);
      chk("relock_edge", lat, SS + LS + RH);
    end
    repeat (3) tick(1'b0, 1'b1);
    chk("saturated_count", {30'd0, bus.loss_count}, FEAT ? CNT_MAX : 32'd0);

    // Reset mid-RUN
    tick(1'b1, 1'b1);
    chk("midrun_rst_out", {31'd0, bus.rst_out}, 32'd1);
    chk("midrun_count", {30'd0, bus.loss_count}, 32'd0);
    lock_latency(lat);
    chk("post_reset_lock_edge", lat, SS + LS + RH);

    // Random lock waveforms with occasional resets
    for (int i = 0; i < 200; i++) begin
      seg = int'($urandom_range(0, 39));
      if (seg == 0) begin
        tick(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        lvl = (seg >= 12);
        len = lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
        repeat (len) tick(1'b0, lvl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_reset_gen.md
Name: pll_lock_reset_gen

Overview:
Consumer end of the PLL lock interface. It samples the asynchronous `locked` output of the 25 MHz PLL in the PLL output clock domain and qualifies it. It then releases a clean synchronous reset to the Ethernet/PipelineC logic only after lock has been stable and a hold time has elapsed. On loss of lock it re-asserts that reset and flags the event.

Parameters:
SYNC_STAGES, 2, synchronizer depth for locked_in (legal >= 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required (legal >= 1)
RST_HOLD_CYCLES, 16, extra cycles rst_out stays high after stability is reached (legal >= 1)
CNT_W, 16, width of loss_count

Ports:
clk  in  1  PLL output clock (25 MHz); the only clock
rst  in  1  synchronous, active-high reset
locked_in  in  1  raw PLL lock indication; asynchronous, may glitch
rst_out  out  1  synchronous active-high reset to downstream logic; registered
ready  out  1  high only in RUN; exact complement of rst_out; registered
lock_lost_pulse  out  1  one-cycle pulse when lock drops while in RUN
loss_count  out  CNT_W  saturating count of lock-loss events (feature-gated, see below)

Behaviour:
- Reset (rst=1 at an edge), effective at that edge: state=WAIT_LOCK, synchronizer flops=0, counters=0, rst_out=1, ready=0, lock_lost_pulse=0, loss_count=0. rst overrides all other events in the same cycle, including rst asserted mid-RUN.
- locked_s is locked_in delayed through SYNC_STAGES flops. No other logic reads locked_in.
- States:
  - WAIT_LOCK: counter=0. If locked_s=1, go to STABLE.
  - STABLE: counter increments each cycle locked_s=1. If locked_s=0, go to WAIT_LOCK and clear the counter. When LOCK_STABLE_CYCLES consecutive ones have been seen, go to HOLD and clear the counter.
  - HOLD: counter runs RST_HOLD_CYCLES. If locked_s=0, go to WAIT_LOCK. On completion, go to RUN.
  - RUN: rst_out=0, ready=1. If locked_s=0, go to WAIT_LOCK and fire lock_lost_pulse.
- Timing. Edge 0 is the first edge sampling locked_in=1 after a low period, with locked_in held high thereafter.
  - rst_out falls and ready rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES exactly.
- Loss timing. Edge 0 is the first edge sampling locked_in=0 while in RUN.
  - rst_out rises and ready falls at edge SYNC_STAGES.
  - lock_lost_pulse is high for exactly the cycle following that edge.
- A drop during STABLE or HOLD aborts to WAIT_LOCK silently: no pulse, no count, and the full count restarts from zero.
- Any single-cycle glitch that reaches locked_s, in any state other than WAIT_LOCK, forces a return to WAIT_LOCK.
- rst_out never glitches low: it is driven from a flop set by state==RUN only.
- Counter width is clog2(max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES))+1. Counters do not wrap.

Optional Feature:
PLL_LOSS_COUNT_EN
- Defined: loss_count increments by 1 on each lock_lost_pulse and saturates at 2^CNT_W-1 (holds, no wrap). It is cleared only by rst.
- Undefined: loss_count is tied to 0 and no counter flops are generated. The port is still present.

Decomposition:
- Package pll_mon_pkg: state enum typedef (WAIT_LOCK, STABLE, HOLD, RUN), the counter-width function, and parameter-legality check constants.
- One sub-module: bit_sync, an N-stage single-bit synchronizer with synchronous active-high reset to 0. It is instantiated once with SYNC_STAGES.

Test Plan:
(All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4.)
- Reset/idle: rst high 3 cycles with locked_in=0, then low 50 cycles -> rst_out=1, ready=0, pulse=0, loss_count=0 throughout.
- Clean lock: locked_in rises at edge 0 and stays high -> rst_out falls and ready rises at edge 14 exactly, then stay there.
- Glitch in STABLE: locked_in low for 1 cycle at edge 5 -> count restarts. rst_out falls 14 edges after locked_in returns high. No pulse, loss_count=0.
- Loss in RUN: from RUN, drop locked_in at edge 0 -> rst_out=1 at edge 2, pulse high 1 cycle, loss_count=1 (feature on) / 0 (feature off). Relock then yields RUN again after 14 edges.
- Saturation (CNT_W=2, feature on): 5 RUN losses -> loss_count sequence 1,2,3,3,3.
- Reset mid-RUN: assert rst 1 cycle while in RUN with locked_in=1 -> rst_out=1 at that edge, loss_count=0, no pulse. RUN re-entered 14 edges after rst deasserts.
